// File: rtl/tone_detect.sv
// Tone detector: measures the spacing of tone_in transitions and locks when
// MATCH_COUNT consecutive half-periods fall inside HALF_PERIOD +/- TOLERANCE.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no reference edge yet; the next edge only starts the counter
// MEASURE | measuring half-periods, counting consecutive matches
// LOCKED  | tone present; detect high until a mismatch or timeout
module tone_detect #(
    parameter int HALF_PERIOD = 28409,
    parameter int TOLERANCE   = 64,
    parameter int MATCH_COUNT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tone_in,
    output logic        detect,
    output logic [15:0] half_period,
    output logic        period_valid,
    output logic        lost
);

    // Bounds kept in 17 bits so HALF_PERIOD+TOLERANCE may exceed the counter range.
    localparam logic [16:0] HI_LIM    = 17'(HALF_PERIOD + TOLERANCE);
    localparam logic [16:0] LO_LIM    = (HALF_PERIOD > TOLERANCE) ? 17'(HALF_PERIOD - TOLERANCE) : 17'd0;
    localparam logic [3:0]  MATCH_MAX = 4'(MATCH_COUNT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEASURE,
        S_LOCKED
    } state_t;

    state_t      state, state_next;
    logic        sync1, sync2, sync_prev;
    logic [15:0] cnt;
    logic [3:0]  mcnt, mcnt_next;
    logic [16:0] cnt_ext;
    logic        edge_evt, meas_evt, in_tol, timeout, lost_next;

    assign edge_evt = sync2 ^ sync_prev;
    assign meas_evt = edge_evt && (state != S_IDLE);
    assign cnt_ext  = {1'b0, cnt};
    assign in_tol   = (cnt_ext >= LO_LIM) && (cnt_ext <= HI_LIM);
    // An edge arriving in the same cycle wins over the timeout.
    assign timeout  = (state != S_IDLE) && !edge_evt && (cnt_ext > HI_LIM);

    always_comb begin
        mcnt_next = mcnt;
        if (meas_evt) begin
            if (!in_tol)
                mcnt_next = 4'd0;
            else if (mcnt >= MATCH_MAX)
                mcnt_next = MATCH_MAX;
            else
                mcnt_next = mcnt + 4'd1;
        end else if (timeout) begin
            mcnt_next = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (edge_evt)
                    state_next = S_MEASURE;
            end
            S_MEASURE: begin
                if (meas_evt && in_tol && (mcnt_next >= MATCH_MAX))
                    state_next = S_LOCKED;
                else if (timeout)
                    state_next = S_IDLE;
            end
            S_LOCKED: begin
                if (meas_evt && !in_tol)
                    state_next = S_MEASURE;
                else if (timeout)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        detect    = (state == S_LOCKED);
        lost_next = (state == S_LOCKED) && ((meas_evt && !in_tol) || timeout);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            sync_prev    <= 1'b0;
            cnt          <= 16'd0;
            mcnt         <= 4'd0;
            half_period  <= 16'd0;
            period_valid <= 1'b0;
            lost         <= 1'b0;
        end else begin
            sync1        <= tone_in;
            sync2        <= sync1;
            sync_prev    <= sync2;
            mcnt         <= mcnt_next;
            period_valid <= meas_evt;
            lost         <= lost_next;
            if (edge_evt)
                cnt <= 16'd1;
            else if (cnt != 16'hFFFF)
                cnt <= cnt + 16'd1;
            if (meas_evt)
                half_period <= cnt;
        end
    end

endmodule
